// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit and the Controller.
// Contents: fetch FSM state enum, {pc, instr} FIFO entry, NOP encoding, major opcodes.
package ifetch_pkg;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StDrain
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_RTYPE  = 7'h33;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries for the fetch unit.
// Ports: clk_i, rst_n_i (async active-low), flush_i (empties, wins over push/pop),
//        push_i/push_data_i, pop_i, head_o (oldest entry), count_o, empty_o, full_o.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned  DEPTH = 2,
    localparam int unsigned CntW  = $clog2(DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  fetch_entry_t    push_data_i,
    input  logic            pop_i,
    output fetch_entry_t    head_o,
    output logic [CntW-1:0] count_o,
    output logic            empty_o,
    output logic            full_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO can still accept a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: keeps the PC, issues word fetches over req/gnt/rvalid,
// buffers responses and hands {pc, instr} to decode over valid/ready.
// Ports:
//   clk_i, rst_n_i                    clock, async active-low reset
//   imem_req_o, imem_addr_o           fetch request and word-aligned address
//   imem_gnt_i, imem_rvalid_i,
//   imem_rdata_i                      grant, in-order response valid and data
//   redirect_i, redirect_pc_i         one-cycle restart at a new PC (flushes)
//   instr_valid_o, instr_ready_i,
//   instr_o, pc_o                     decode handshake and FIFO head
//   misalign_o                        sticky misaligned-redirect flag (only with
//                                     IFETCH_MISALIGN_CHK_EN defined)
// Build option: IFETCH_MISALIGN_CHK_EN enables the misaligned-redirect check.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
`ifdef IFETCH_MISALIGN_CHK_EN
    output logic [31:0] pc_o,
    output logic        misalign_o
`else
    output logic [31:0] pc_o
`endif
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SumW = CntW + 1;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0] outst_q, outst_d;
    logic [CntW-1:0] fifo_count;
    logic            fifo_empty, fifo_full;
    fetch_entry_t    fifo_head, last_q, push_entry;
    logic [SumW-1:0] credits_used;
    logic [31:0]     redirect_target;
    logic            grant, resp, push, pop;
    logic            halt, misalign_set;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic misalign_q;

    assign misalign_set = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign halt         = misalign_q;
    assign misalign_o   = misalign_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) misalign_q <= 1'b0;
        else          misalign_q <= misalign_q | misalign_set;
    end
`else
    assign misalign_set = 1'b0;
    assign halt         = 1'b0;
`endif

    assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;

    // Every buffered word and every in-flight request holds one FIFO slot.
    assign credits_used = SumW'(fifo_count) + SumW'(outst_q);
    assign imem_req_o   = (state_q == StRun) && !halt && (credits_used < SumW'(FIFO_DEPTH));
    assign imem_addr_o  = fetch_pc_q;

    assign grant = imem_req_o && imem_gnt_i;
    // Responses with nothing outstanding (e.g. from before a reset) are ignored.
    assign resp  = imem_rvalid_i && (outst_q != '0);
    assign pop   = instr_valid_o && instr_ready_i && !redirect_i;
    assign push  = resp && (state_q == StRun) && !redirect_i && (!fifo_full || pop);

    // In RUN all in-flight requests are consecutive words ending at fetch_pc - 4,
    // so the oldest one (the one answering now) sits outst_q words back.
    assign push_entry.pc    = fetch_pc_q - (32'(outst_q) << 2);
    assign push_entry.instr = imem_rdata_i;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + CntW'(grant) - CntW'(resp);

        if (redirect_i)  fetch_pc_d = redirect_target;
        else if (grant)  fetch_pc_d = fetch_pc_q + 32'd4;

        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun: begin
                if (redirect_i && ((outst_d != '0) || misalign_set)) state_d = StDrain;
            end
            StDrain: begin
                if (!redirect_i && (outst_d == '0)) state_d = StRun;
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StBoot;
            fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
            outst_q    <= '0;
            last_q     <= '{pc: RESET_PC, instr: NOP_INSTR};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            if (pop) last_q <= fifo_head;
        end
    end

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .flush_i     (redirect_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // Decode sees the last consumed entry while the FIFO is empty.
    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_empty ? last_q.instr : fifo_head.instr;
    assign pc_o          = fifo_empty ? last_q.pc    : fifo_head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed table, hand-written corner
// sequences, and a randomized run against a stream-level reference model.
module tb_instr_fetch;
    import ifetch_pkg::*;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
`ifdef IFETCH_MISALIGN_CHK_EN
        .pc_o          (pc),
        .misalign_o    (misalign)
`else
        .pc_o          (pc)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Memory contents: an address-dependent word, never equal to NOP in practice.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]} + 32'h1357_9BDF;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Memory model: addresses granted but not yet answered, in order.
    logic [31:0] pend_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q.delete();
        end else begin
            if (imem_rvalid && pend_q.size() != 0) void'(pend_q.pop_front());
            if (imem_req && imem_gnt) pend_q.push_back(imem_addr);
        end
    end

    // Applied at a negedge; rvalid only when the memory has something to answer.
    task automatic drive(input logic g, input logic rv, input logic rdy, input logic rd,
                         input logic [31:0] rpc);
        imem_gnt    = g;
        imem_rvalid = rv && (pend_q.size() != 0);
        imem_rdata  = (pend_q.size() != 0) ? mem_word(pend_q[0]) : 32'hDEAD_BEEF;
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    task automatic check_reset_vals(input string nm);
        check32({nm, ".req"},   32'(imem_req), 32'd0);
        check32({nm, ".addr"},  imem_addr, RESET_PC);
        check32({nm, ".valid"}, 32'(instr_valid), 32'd0);
        check32({nm, ".instr"}, instr, NOP_INSTR);
        check32({nm, ".pc"},    pc, RESET_PC);
    endtask

    // Leaves the bench at the negedge on which reset is released (BOOT cycle).
    task automatic do_reset(input string nm);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals(nm);
        rst_n = 1'b1;
    endtask

    // Free-running memory with ready=1: expects n entries starting at first_pc.
    task automatic expect_stream(input string nm, input logic [31:0] first_pc, input int n,
                                 input logic chk_req);
        int  got = 0;
        logic seen_req = 1'b0;
        for (int c = 0; c < 40 && got < n; c++) begin
            if (chk_req && imem_req && !seen_req) begin
                check32({nm, ".first_req"}, imem_addr, first_pc);
                seen_req = 1'b1;
            end
            if (instr_valid) begin
                check32($sformatf("%s.pc%0d", nm, got), pc, first_pc + 32'(4 * got));
                check32($sformatf("%s.instr%0d", nm, got), instr, mem_word(first_pc + 32'(4 * got)));
                got++;
            end
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            @(negedge clk);
        end
        checks++;
        if (got < n) begin
            errors++;
            $display("FAIL %s.timeout: got %0d entries required %0d", nm, got, n);
        end
    endtask

    typedef struct {
        logic        g, rv, rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
    } vec_t;

    function automatic vec_t mk(input logic g, input logic rv, input logic rdy, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.g = g; v.rv = rv; v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        int pops;
        logic [31:0] m_fetch, m_pc;
        logic exp_empty;

        // Back-to-back fetch, 1-cycle memory, ready=1. Row 0 is the BOOT cycle.
        tbl[0] = mk(1, 0, 1, 0, 32'h0,  0, 32'h0, NOP_INSTR);
        tbl[1] = mk(1, 0, 1, 1, 32'h0,  0, 32'h0, NOP_INSTR);
        tbl[2] = mk(1, 1, 1, 1, 32'h4,  0, 32'h0, NOP_INSTR);
        tbl[3] = mk(1, 1, 1, 0, 32'h8,  1, 32'h0, mem_word(32'h0));
        tbl[4] = mk(1, 0, 1, 1, 32'h8,  1, 32'h4, mem_word(32'h4));
        tbl[5] = mk(1, 1, 1, 1, 32'hC,  0, 32'h4, mem_word(32'h4));
        tbl[6] = mk(1, 1, 1, 0, 32'h10, 1, 32'h8, mem_word(32'h8));
        tbl[7] = mk(0, 0, 0, 1, 32'h10, 1, 32'hC, mem_word(32'hC));

        @(negedge clk);
        do_reset("rst0");
        for (int i = 0; i < 8; i++) begin
            check32($sformatf("t1[%0d].req", i),   32'(imem_req), 32'(tbl[i].e_req));
            check32($sformatf("t1[%0d].addr", i),  imem_addr, tbl[i].e_addr);
            check32($sformatf("t1[%0d].valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
            check32($sformatf("t1[%0d].pc", i),    pc, tbl[i].e_pc);
            check32($sformatf("t1[%0d].instr", i), instr, tbl[i].e_instr);
            drive(tbl[i].g, tbl[i].rv, tbl[i].rdy, 1'b0, 32'h0);
            @(negedge clk);
        end

        // Backpressure: only FIFO_DEPTH requests, then one pop per cycle.
        do_reset("rst1");
        grants = 0;
        for (int c = 0; c < 8; c++) begin
            if (imem_req) grants++;
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
        end
        check32("bp.grants", 32'(grants), 32'(FIFO_DEPTH));
        check32("bp.req_off", 32'(imem_req), 32'd0);
        check32("bp.head_pc", pc, 32'h0);
        check32("bp.head_instr", instr, mem_word(32'h0));
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check32("bp.pop1_valid", 32'(instr_valid), 32'd1);
        check32("bp.pop1_pc", pc, 32'h4);
        check32("bp.resume_req", 32'(imem_req), 32'd1);
        check32("bp.resume_addr", imem_addr, 32'h8);

        // Redirect with two requests in flight.
        do_reset("rst2");
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            @(negedge clk);
        end
        check32("rd1.credit_stop", 32'(imem_req), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
        @(negedge clk);
        check32("rd1.flushed", 32'(instr_valid), 32'd0);
        check32("rd1.drain_noreq", 32'(imem_req), 32'd0);
        expect_stream("rd1", 32'h100, 2, 1'b1);

        // Redirect in the same cycle as a response.
        do_reset("rst3");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
        @(negedge clk);
        check32("rd2.empty", 32'(instr_valid), 32'd0);
        check32("rd2.req", 32'(imem_req), 32'd1);
        check32("rd2.addr", imem_addr, 32'h200);
        expect_stream("rd2", 32'h200, 2, 1'b1);

        // Address wrap at the top of the address space.
        do_reset("rst4");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk);
        check32("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check32("wrap.addr1", imem_addr, 32'h0000_0000);
        expect_stream("wrap", 32'hFFFF_FFFC, 3, 1'b0);

`ifdef IFETCH_MISALIGN_CHK_EN
        do_reset("rst5");
        check32("mis.init", 32'(misalign), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h102);
        @(negedge clk);
        grants = 0;
        for (int c = 0; c < 12; c++) begin
            if (imem_req) grants++;
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            @(negedge clk);
        end
        check32("mis.flag", 32'(misalign), 32'd1);
        check32("mis.noreq", 32'(grants), 32'd0);
`else
        do_reset("rst5");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h303);
        @(negedge clk);
        check32("lowbits.addr", imem_addr, 32'h300);
        expect_stream("lowbits", 32'h300, 1, 1'b0);
`endif

        // Randomized run against a stream-level model.
        do_reset("rst6");
        m_fetch   = RESET_PC;
        m_pc      = RESET_PC;
        exp_empty = 1'b0;
        pops      = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        g, rv, rdy, rd;
            logic [31:0] rpc;
            g   = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 40) == 0);
            rpc = $urandom();
`ifdef IFETCH_MISALIGN_CHK_EN
            rpc = rpc & 32'hFFFF_FFFC;
`endif
            if (exp_empty) check32("rnd.flush", 32'(instr_valid), 32'd0);
            exp_empty = 1'b0;
            checks++;
            if (pend_q.size() > FIFO_DEPTH) begin
                errors++;
                $display("FAIL rnd.outstanding: got %0d required <= %0d", pend_q.size(), FIFO_DEPTH);
            end
            if (imem_req && g) begin
                check32("rnd.addr", imem_addr, m_fetch);
                m_fetch = m_fetch + 32'd4;
            end
            if (instr_valid && rdy && !rd) begin
                check32("rnd.pc", pc, m_pc);
                check32("rnd.instr", instr, mem_word(m_pc));
                m_pc = m_pc + 32'd4;
                pops++;
            end
            if (rd) begin
                m_fetch   = rpc & 32'hFFFF_FFFC;
                m_pc      = rpc & 32'hFFFF_FFFC;
                exp_empty = 1'b1;
            end
            drive(g, rv, rdy, rd, rpc);
            @(negedge clk);
        end
        checks++;
        if (pops < 200) begin
            errors++;
            $display("FAIL rnd.progress: got %0d entries required >= 200", pops);
        end

        // Reset mid-operation, then stray responses with nothing outstanding.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        check32("stray.valid0", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check32("stray.valid1", 32'(instr_valid), 32'd0);
        check32("stray.req", 32'(imem_req), 32'd1);
        check32("stray.addr", imem_addr, RESET_PC);
        imem_rvalid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit; it produces the 32-bit instruction word that the main Controller decodes.
- Keeps the PC and issues word requests to instruction memory over a req/gnt/rvalid protocol.
- Buffers returned words in a small FIFO and presents {pc, instr} to decode with a valid/ready handshake.
- Handles a redirect (branch taken) by flushing in-flight and buffered words.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, buffered instruction entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock, all state on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- imem_req_o  out  1  fetch request to instruction memory.
- imem_addr_o  out  32  word-aligned fetch address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response data valid; responses return in request order, at least 1 cycle after gnt.
- imem_rdata_i  in  32  response instruction word.
- redirect_i  in  1  one-cycle pulse: restart fetch at redirect_pc_i.
- redirect_pc_i  in  32  new PC.
- instr_valid_o  out  1  instr_o and pc_o hold a valid entry.
- instr_ready_i  in  1  decode consumes the entry when valid and ready are both high.
- instr_o  out  32  instruction word to the Controller.
- pc_o  out  32  address of instr_o.

Behaviour:
- Reset values (asynchronous, active-low):
  - imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=RESET_PC.
  - FIFO empty, outstanding count=0, state BOOT.
- FSM states: BOOT, RUN, DRAIN.
  - BOOT: one cycle after reset release, then RUN. This guarantees no request in the first cycle.
  - RUN:
    - imem_req_o=1 while (fifo_count + outstanding) < FIFO_DEPTH.
    - On req&&gnt: outstanding+1, fetch_pc+=4 (wraps modulo 2^32).
    - On rvalid: push {addr, rdata} into the FIFO, outstanding-1.
    - req&&gnt and rvalid in the same cycle leave outstanding unchanged.
  - DRAIN: imem_req_o=0. Each rvalid is discarded and decrements outstanding. When outstanding==0, go to RUN.
- Redirect handling (redirect_i=1):
  - Takes priority over all events in the same cycle.
  - FIFO flushed; instr_valid_o=0 next cycle.
  - fetch_pc=redirect_pc_i.
  - A grant in the redirect cycle still counts as outstanding and is discarded.
  - A response in the redirect cycle is discarded.
  - Next state: DRAIN if post-cycle outstanding>0, else RUN.
  - A redirect received in DRAIN overwrites fetch_pc and stays in DRAIN.
- Decode interface:
  - instr_valid_o = FIFO not empty.
  - instr_o and pc_o come from the FIFO head. When empty they hold the last value, or NOP/RESET_PC after reset.
  - Pop on valid&&ready.
- FIFO boundaries:
  - Push and pop in the same cycle are allowed, including when full.
  - Overflow cannot occur because requests are gated by credits.
- Latency:
  - First imem_req_o in cycle 2 after reset release.
  - A response with rvalid in cycle N gives instr_valid_o in cycle N+1 (registered FIFO).
- imem_addr_o = fetch_pc, bits [1:0] are always 0. redirect_pc_i[1:0] is ignored (forced to 0) unless the optional feature is enabled.
- Reset asserted mid-operation: everything returns to reset values immediately. Responses arriving after reset release with outstanding==0 are ignored.

Optional Feature:
- Macro IFETCH_MISALIGN_CHK_EN.
- Enabled:
  - Adds output misalign_o (1 bit, sticky, reset 0).
  - A redirect with redirect_pc_i[1:0]!=0 sets misalign_o, flushes the FIFO and enters DRAIN.
  - After draining, the FSM stays in RUN with requests suppressed until reset.
- Disabled: no port; low address bits are silently forced to 0.

Decomposition:
- Package ifetch_pkg:
  - state enum {BOOT, RUN, DRAIN}.
  - NOP_INSTR=32'h0000_0013.
  - Opcode constants OPC_LOAD=7'h03, OPC_STORE=7'h23, OPC_RTYPE=7'h33, OPC_BRANCH=7'h63, shared with the Controller.
- One sub-module, ifetch_fifo: parameterised sync FIFO of {pc, instr} with flush, push, pop, count, empty and full.

Test Plan:
- Reset release, gnt=1, rvalid one cycle after each grant, ready=1 -> addresses 0x0,0x4,0x8 issued back-to-back; instr_o matches rdata in order with pc_o 0x0,0x4,0x8.
- ready=0 and gnt=1 -> exactly 2 requests issued, then imem_req_o=0. Raise ready -> one entry popped per cycle, requests resume.
- Two outstanding requests, redirect_i with pc=0x100 -> both responses discarded; next request at 0x100, first instr_valid_o shows pc_o=0x100.
- Redirect to 0x200 and rvalid in the same cycle -> that response dropped, FIFO empty the next cycle.
- Fetch at 0xFFFF_FFFC -> next address 0x0000_0000.
- With IFETCH_MISALIGN_CHK_EN, redirect to 0x102 -> misalign_o=1 and no further imem_req_o until reset.
